// File: rtl/game_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : game_tick_scheduler
// Purpose  : Paces snake-game updates from a programmable-period tick counter,
//            with request/done handshake, speed-up, pause and overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module game_tick_scheduler #(
    parameter int                PERIOD_DUMMY_UNUSED = 0,
    parameter int                DWIDTH      = 24,
    parameter logic [DWIDTH-1:0] PERIOD_INIT = 24'd2_500_000,
    parameter logic [DWIDTH-1:0] PERIOD_MIN  = 24'd500_000,
    parameter logic [DWIDTH-1:0] PERIOD_STEP = 24'd100_000,
    parameter int                CWIDTH      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              speed_up,
    input  logic              update_done,
    output logic              update_req,
    output logic [DWIDTH-1:0] period,
    output logic [CWIDTH-1:0] tick_count,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REQ    = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    // One extra bit so the floor test cannot wrap for large parameter values.
    localparam logic [DWIDTH:0] c_min_plus_step = {1'b0, PERIOD_MIN} + {1'b0, PERIOD_STEP};

    state_t            r_state;
    logic [DWIDTH-1:0] r_cnt;
    logic [DWIDTH-1:0] r_period;
    logic              r_update_req;
    logic [CWIDTH-1:0] r_tick_count;
    logic              r_overrun;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [DWIDTH-1:0] w_cnt_nxt;
    logic [DWIDTH-1:0] w_period_nxt;
    logic              w_req_nxt;
    logic [CWIDTH-1:0] w_tick_count_nxt;
    logic              w_overrun_nxt;
    logic              w_tick;
    logic [DWIDTH-1:0] w_period_dec;
    logic [DWIDTH-1:0] w_cnt_inc;
    logic [CWIDTH-1:0] w_tick_count_inc;

    // Greater-or-equal keeps ticking even if a speed-up left cnt past the new end.
    assign w_tick           = (r_cnt >= (r_period - DWIDTH'(1)));
    assign w_period_dec     = ({1'b0, r_period} < c_min_plus_step) ? PERIOD_MIN
                                                                   : (r_period - PERIOD_STEP);
    assign w_cnt_inc        = r_cnt + DWIDTH'(1);
    assign w_tick_count_inc = r_tick_count + CWIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_period     <= PERIOD_INIT;
            r_update_req <= 1'b0;
            r_tick_count <= '0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_period     <= w_period_nxt;
            r_update_req <= w_req_nxt;
            r_tick_count <= w_tick_count_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_period_nxt     = r_period;
        w_req_nxt        = r_update_req;
        w_tick_count_nxt = r_tick_count;
        w_overrun_nxt    = r_overrun;

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            if (speed_up && (r_state != S_IDLE)) begin
                w_period_nxt = w_period_dec;
            end

            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    w_req_nxt = 1'b0;
                    if (start) begin
                        w_period_nxt     = PERIOD_INIT;
                        w_tick_count_nxt = '0;
                        w_overrun_nxt    = 1'b0;
                        w_state_nxt      = S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_tick) begin
                        w_cnt_nxt        = '0;
                        w_req_nxt        = 1'b1;
                        w_tick_count_nxt = w_tick_count_inc;
                        w_state_nxt      = S_REQ;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (pause) begin
                            w_state_nxt = S_PAUSED;
                        end
                    end
                end

                S_REQ: begin
                    if (w_tick) begin
                        w_cnt_nxt = '0;
                        if (update_done) begin
                            w_tick_count_nxt = w_tick_count_inc;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (update_done) begin
                            w_req_nxt   = 1'b0;
                            w_state_nxt = S_RUN;
                        end
                    end
                end

                S_PAUSED: begin
                    w_req_nxt = 1'b0;
                    if (!pause) begin
                        w_state_nxt = S_RUN;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign update_req = r_update_req;
    assign period     = r_period;
    assign tick_count = r_tick_count;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_tick_scheduler
// Purpose  : Directed self-checking bench for game_tick_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        speed_up = 1'b0;
    logic        update_done = 1'b0;
    logic        update_req;
    logic [7:0]  period;
    logic [15:0] tick_count;
    logic        overrun;
    logic        busy;

    int   n_checks = 0;
    int   n_pass = 0;
    int   ncyc = 0;
    int   nrise = 0;
    int   nseen = 0;
    int   last_rise = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .DWIDTH      (8),
        .PERIOD_INIT (8'd10),
        .PERIOD_MIN  (8'd4),
        .PERIOD_STEP (8'd3),
        .CWIDTH      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .speed_up    (speed_up),
        .update_done (update_done),
        .update_req  (update_req),
        .period      (period),
        .tick_count  (tick_count),
        .overrun     (overrun),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance to the next falling edge and record any update_req rise.
    task automatic step();
        @(negedge clk);
        ncyc++;
        if (update_req && !req_prev) begin
            nrise++;
            last_rise = ncyc;
        end
        req_prev = update_req;
    endtask

    task automatic wait_rise(output int r);
        int k;
        k = 0;
        while (nrise == nseen && k < 100) begin
            step();
            k++;
        end
        if (nrise == nseen) begin
            n_checks++;
            $display("FAIL wait_rise: no update_req rise within 100 cycles (cycle %0d)", ncyc);
            r = ncyc;
        end else begin
            nseen = nrise;
            r = last_rise;
        end
    endtask

    task automatic serve(input int dly);
        repeat (dly) step();
        update_done = 1'b1;
        step();
        update_done = 1'b0;
    endtask

    initial begin
        int s, r1, r2, r3, r4, r5, r6, r7, r8, r9;

        repeat (3) step();
        check("rst_req",      32'(update_req), 32'd0);
        check("rst_period",   32'(period),     32'd10);
        check("rst_tick_cnt", 32'(tick_count), 32'd0);
        check("rst_overrun",  32'(overrun),    32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        reset = 1'b1;
        step();

        start = 1'b1; step(); start = 1'b0;
        s = ncyc;
        check("busy_after_start", 32'(busy), 32'd1);

        // Basic pacing, done two cycles after each request
        wait_rise(r1);
        check("first_req_latency", 32'(r1 - s), 32'd10);
        check("tick_cnt_1",        32'(tick_count), 32'd1);
        check("overrun_0",         32'(overrun), 32'd0);
        serve(2);
        check("req_cleared", 32'(update_req), 32'd0);
        wait_rise(r2);
        check("req_spacing_10", 32'(r2 - r1), 32'd10);
        check("tick_cnt_2",     32'(tick_count), 32'd2);
        serve(2);
        wait_rise(r3);
        check("req_spacing_10b", 32'(r3 - r2), 32'd10);
        check("tick_cnt_3",      32'(tick_count), 32'd3);

        // Done coincident with the next tick
        repeat (9) step();
        update_done = 1'b1; step(); update_done = 1'b0;
        r4 = ncyc;
        check("coinc_req_high", 32'(update_req), 32'd1);
        check("coinc_tick_cnt", 32'(tick_count), 32'd4);
        check("coinc_overrun",  32'(overrun),    32'd0);
        check("coinc_no_rise",  32'(nrise),      32'd3);

        // Withheld done
        repeat (9) step();
        check("overrun_before", 32'(overrun), 32'd0);
        step();
        check("overrun_set",      32'(overrun),    32'd1);
        check("overrun_req_high", 32'(update_req), 32'd1);
        check("overrun_tick_cnt", 32'(tick_count), 32'd4);
        repeat (5) step();
        update_done = 1'b1; step(); update_done = 1'b0;
        check("late_done_req",  32'(update_req), 32'd0);
        check("overrun_sticky", 32'(overrun),    32'd1);
        wait_rise(r5);
        check("after_overrun_spacing", 32'(r5 - r4), 32'd20);
        check("tick_cnt_5",            32'(tick_count), 32'd5);

        // Pause raised in REQ is deferred until done
        pause = 1'b1;
        step(); step();
        check("pause_deferred", 32'(update_req), 32'd1);
        update_done = 1'b1; step(); update_done = 1'b0;
        check("pause_done_req", 32'(update_req), 32'd0);
        repeat (20) step();
        check("paused_req",  32'(update_req), 32'd0);
        check("paused_busy", 32'(busy),       32'd1);
        pause = 1'b0;
        wait_rise(r6);
        check("resume_spacing", 32'(r6 - r5), 32'd30);
        check("tick_cnt_6",     32'(tick_count), 32'd6);

        // Speed-up with saturation at the floor
        serve(2);
        speed_up = 1'b1; step(); speed_up = 1'b0;
        check("period_7", 32'(period), 32'd7);
        speed_up = 1'b1; step(); speed_up = 1'b0;
        check("period_4", 32'(period), 32'd4);
        speed_up = 1'b1; step(); speed_up = 1'b0;
        check("period_sat", 32'(period), 32'd4);
        wait_rise(r7);
        check("speedup_tick_spacing", 32'(r7 - r6), 32'd6);
        serve(0);
        wait_rise(r8);
        check("req_spacing_4", 32'(r8 - r7), 32'd4);
        serve(0);
        wait_rise(r9);
        check("req_spacing_4b", 32'(r9 - r8), 32'd4);
        check("tick_cnt_9",     32'(tick_count), 32'd9);

        // Asynchronous reset while a request is pending
        #2 reset = 1'b0;
        #1;
        check("arst_req",      32'(update_req), 32'd0);
        check("arst_period",   32'(period),     32'd10);
        check("arst_tick_cnt", 32'(tick_count), 32'd0);
        check("arst_busy",     32'(busy),       32'd0);
        check("arst_overrun",  32'(overrun),    32'd0);
        step();
        reset = 1'b1;
        step();

        // Stop in REQ holds period; start reloads it
        start = 1'b1; step(); start = 1'b0;
        s = ncyc;
        wait_rise(r1);
        check("restart_latency", 32'(r1 - s), 32'd10);
        speed_up = 1'b1; step(); speed_up = 1'b0;
        check("req_speedup_period", 32'(period), 32'd7);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_req",      32'(update_req), 32'd0);
        check("stop_busy",     32'(busy),       32'd0);
        check("stop_period",   32'(period),     32'd7);
        check("stop_tick_cnt", 32'(tick_count), 32'd1);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("start_with_stop_ignored", 32'(busy), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("start_busy",     32'(busy),       32'd1);
        check("start_period",   32'(period),     32'd10);
        check("start_tick_cnt", 32'(tick_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
